// File: rtl/float_mul_pkg.sv
// Shared types for the float multiplier arbiter.
// Tags pair each in-flight product with its owner.
package float_mul_pkg;

  localparam int FP_W = 32;
  localparam int MUL_LAT_DEFAULT = 16;

  typedef logic [FP_W-1:0] fp32_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } mul_tag_t;

endpackage

// File: rtl/float_mul_arb_rr_arb.sv
// Round-robin grant over N requesters.
// Pointer advances past the winner on every grant.
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  // Scan backwards so the closest requester to ptr wins last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr <= '0;
    end else if (|gnt) begin
      if (gnt_id == PW'(N - 1))
        ptr <= '0;
      else
        ptr <= gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/float_mul_arb.sv
// Shares one pipelined fp32 multiplier between N_REQ requesters.
// A tag pipeline steers every product back to its owner.
module float_mul_arb
  import float_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_din1,
  input  logic [FP_W*N_REQ-1:0] req_din2,
  output logic [N_REQ-1:0]      rsp_valid,
  output fp32_t                 rsp_dout,
  output fp32_t                 mul_din1,
  output fp32_t                 mul_din2,
  output logic                  mul_din_valid,
  input  fp32_t                 mul_dout,
  input  logic                  mul_dout_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]    out_cnt [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             hs;
  mul_tag_t         iss_q;
  mul_tag_t         tag_q [MUL_LAT];
  mul_tag_t         tag_out;
  logic             rsp_hit;
  logic [N_REQ-1:0] rsp_sel;
  logic             tag_any;
  logic             cnt_any;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
  end

  rr_arb #(.N(N_REQ)) u_arb (
    .clk    (clk),
    .nrst   (nrst),
    .req    (elig),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready     = gnt;
  assign hs            = |gnt;
  assign mul_din_valid = iss_q.valid;
  assign tag_out       = tag_q[MUL_LAT-1];
  assign rsp_hit       = mul_dout_valid && tag_out.valid;

  always_comb begin
    rsp_sel = '0;
    cnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_sel[i] = rsp_hit && (tag_out.id == 3'(i));
      cnt_any    = cnt_any | (out_cnt[i] != '0);
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int s = 0; s < MUL_LAT; s++)
      tag_any = tag_any | tag_q[s].valid;
  end

  assign busy = iss_q.valid | tag_any | (|rsp_valid) | cnt_any;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      iss_q    <= '0;
      mul_din1 <= '0;
      mul_din2 <= '0;
    end else begin
      iss_q <= '{valid: hs, id: 3'(gnt_id)};
      if (hs) begin
        mul_din1 <= req_din1[FP_W*int'(gnt_id) +: FP_W];
        mul_din2 <= req_din2[FP_W*int'(gnt_id) +: FP_W];
      end
    end
  end

  // Tag stage s lines up with multiplier stage s+1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < MUL_LAT; s++)
        tag_q[s] <= '0;
    end else begin
      tag_q[0] <= iss_q;
      for (int s = 1; s < MUL_LAT; s++)
        tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid <= '0;
      rsp_dout  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rsp_sel;
      if (rsp_hit)
        rsp_dout <= mul_dout;
      if (mul_dout_valid != tag_out.valid)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_REQ; i++)
        out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && !rsp_sel[i])
          out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (!gnt[i] && rsp_sel[i] && out_cnt[i] != '0)
          out_cnt[i] <= out_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_float_mul_arb.sv
// Directed bench for float_mul_arb.
// Includes a 16-stage truncating fp32 multiplier stand-in.
module tb_float_mul_arb;

  localparam int N = 4;
  localparam int LAT = 16;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_din1 = '0;
  logic [32*N-1:0] req_din2 = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_dout;
  logic [31:0]     mul_din1;
  logic [31:0]     mul_din2;
  logic            mul_din_valid;
  logic [31:0]     mul_dout;
  logic            mul_dout_valid;
  logic            busy;
  logic            err;
  logic            inj = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        pv [LAT];
  logic [31:0] pd [LAT];

  always #5 clk = ~clk;

  float_mul_arb #(.N_REQ(N), .MUL_LAT(LAT), .MAX_OUT(4)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_din1       (req_din1),
    .req_din2       (req_din2),
    .rsp_valid      (rsp_valid),
    .rsp_dout       (rsp_dout),
    .mul_din1       (mul_din1),
    .mul_din2       (mul_din2),
    .mul_din_valid  (mul_din_valid),
    .mul_dout       (mul_dout),
    .mul_dout_valid (mul_dout_valid),
    .busy           (busy),
    .err            (err)
  );

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == '0 || b[30:0] == '0)
      return {s, 31'b0};
    m = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < LAT; s++) begin
        pv[s] <= 1'b0;
        pd[s] <= '0;
      end
    end else begin
      pv[0] <= mul_din_valid;
      pd[0] <= fmul(mul_din1, mul_din2);
      for (int s = 1; s < LAT; s++) begin
        pv[s] <= pv[s-1];
        pd[s] <= pd[s-1];
      end
    end
  end

  assign mul_dout_valid = pv[LAT-1] | inj;
  assign mul_dout       = pd[LAT-1];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from requester r alone and check latency and product.
  task automatic issue_one(input int r, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] p);
    int cyc;
    @(posedge clk);
    #1;
    req_valid[r] = 1'b1;
    req_din1[32*r +: 32] = a;
    req_din2[32*r +: 32] = b;
    @(negedge clk);
    check("one_ready", 32'(req_ready), 32'(1 << r));
    @(posedge clk);
    #1;
    req_valid = '0;
    cyc = 1;
    while (rsp_valid == '0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("one_lat", 32'(cyc), 32'd18);
    check("one_rspv", 32'(rsp_valid), 32'(1 << r));
    check("one_dout", rsp_dout, p);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (busy && c < 80) begin
      @(negedge clk);
      c++;
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  logic [31:0] fv [4];
  logic [31:0] pv4 [4];
  int k;
  int seen;

  initial begin
    fv[0] = 32'h3F800000; fv[1] = 32'h40000000;
    fv[2] = 32'h40400000; fv[3] = 32'h40800000;
    pv4[0] = 32'h40000000; pv4[1] = 32'h40800000;
    pv4[2] = 32'h40C00000; pv4[3] = 32'h41000000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_dout", rsp_dout, 32'd0);
    check("rst_mulv", 32'(mul_din_valid), 32'd0);
    check("rst_din1", mul_din1, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #1 nrst = 1'b1;

    issue_one(0, 32'h40000000, 32'h40400000, 32'h40C00000);
    drain();
    issue_one(2, 32'h3FC00000, 32'hC0000000, 32'hC0400000);
    drain();

    // All four contend: round-robin then ordered responses.
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_din1[32*i +: 32] = fv[i];
      req_din2[32*i +: 32] = 32'h40000000;
    end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_gnt", 32'(req_ready), 32'(1 << ((3 + i) % 4)));
      @(posedge clk);
    end
    #1 req_valid = '0;
    k = 0;
    while (rsp_valid == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 8; i++) begin
      check("rr_rspv", 32'(rsp_valid), 32'(1 << ((3 + i) % 4)));
      check("rr_dout", rsp_dout, pv4[(3 + i) % 4]);
      @(negedge clk);
    end
    drain();

    // Outstanding limit on a lone requester.
    @(posedge clk);
    #1;
    req_din1[31:0] = 32'h40000000;
    req_din2[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      check("lim_ready", 32'(req_ready[0]), 32'((c < 4 || c == 18) ? 1 : 0));
      @(posedge clk);
    end
    #1 req_valid = '0;
    drain();

    // Reset with five operations in flight.
    @(posedge clk);
    #1 req_valid = '1;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("mid_norsp", 32'(seen), 32'd0);
    check("mid_busy2", 32'(busy), 32'd0);
    issue_one(1, 32'h3FC00000, 32'hC0000000, 32'hC0400000);
    drain();

    // Spurious multiplier valid with empty tag pipeline.
    check("pre_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("inj_err", 32'(err), 32'd1);
    check("inj_norsp", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
